// File: rtl/hkspi_pkg.sv
// ============================================================================
// Module      : hkspi_pkg
// Description : Shared constants and types for the housekeeping SPI responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package hkspi_pkg;

    localparam int BIT_CNT_W = 3;

    localparam logic [7:0] HKSPI_CMD_WRITE = 8'h80;
    localparam logic [7:0] HKSPI_CMD_READ  = 8'h40;
    localparam logic [7:0] HKSPI_CMD_RW    = 8'hC0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } hkspi_state_e;

endpackage

`default_nettype wire

// File: rtl/hkspi_sync.sv
// ============================================================================
// Module      : hkspi_sync
// Description : Parameterised-width 2-FF synchroniser, per-bit reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module hkspi_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/hkspi_responder.sv
// ============================================================================
// Module      : hkspi_responder
// Description : Oversampled housekeeping SPI responder (mode 0) with a
//               byte-wide register port. Optional HKSPI_RESP_NBYTE_EN enables
//               the byte-count field in command bits [5:3].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module hkspi_responder
    import hkspi_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sck,
    input  logic              csb,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_we,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    logic [2:0]           w_pins_s;
    logic                 r_sck_d, r_rise, r_sdi_d, r_csb_d;
    hkspi_state_e         r_state, w_state_nxt;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [6:0]           r_rx_sr;
    logic [7:0]           w_rx_byte, r_tx_sr, r_wdata;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_rd, r_wr, r_we, r_byte_end, r_load, r_tx_valid;
    logic                 w_shift_en, w_byte_done, w_cmd_ok, w_last_byte;

    // csb synchroniser bit resets high so the link looks deselected
    hkspi_sync #(
        .WIDTH   (3),
        .RST_VAL (3'b010)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .i_d   ({sck, csb, sdi}),
        .o_q   (w_pins_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sck_d <= 1'b0;
            r_rise  <= 1'b0;
            r_sdi_d <= 1'b0;
            r_csb_d <= 1'b1;
        end else begin
            r_sck_d <= w_pins_s[2];
            r_rise  <= w_pins_s[2] & ~r_sck_d;
            r_sdi_d <= w_pins_s[0];
            r_csb_d <= w_pins_s[1];
        end
    end

    assign w_rx_byte   = {r_rx_sr, r_sdi_d};
    assign w_shift_en  = r_rise & ~r_csb_d & (r_state != ST_IGNORE);
    assign w_byte_done = w_shift_en & (r_bit_cnt == BIT_CNT_W'(7));

`ifdef HKSPI_RESP_NBYTE_EN
    logic [2:0] r_nleft;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_nleft <= 3'd0;
        end else if (r_csb_d) begin
            r_nleft <= 3'd0;
        end else if (w_byte_done && r_state == ST_CMD) begin
            r_nleft <= w_rx_byte[5:3];
        end else if (w_byte_done && r_state == ST_DATA && r_nleft != 3'd0) begin
            r_nleft <= r_nleft - 3'd1;
        end
    end

    assign w_cmd_ok    = (w_rx_byte[7:6] != 2'b00) && (w_rx_byte[2:0] == 3'b000);
    assign w_last_byte = (r_nleft == 3'd1);
`else
    assign w_cmd_ok    = (w_rx_byte[7:6] != 2'b00) && (w_rx_byte[5:0] == 6'd0);
    assign w_last_byte = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A deselect overrides everything, including a coincident 8th bit
    always_comb begin
        w_state_nxt = r_state;
        if (r_csb_d) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_CMD;
                ST_CMD:  if (w_byte_done) w_state_nxt = w_cmd_ok ? ST_ADDR : ST_IGNORE;
                ST_ADDR: if (w_byte_done) w_state_nxt = ST_DATA;
                ST_DATA: if (w_byte_done && w_last_byte) w_state_nxt = ST_IGNORE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_rx_sr    <= '0;
            r_tx_sr    <= '0;
            r_wdata    <= '0;
            r_addr     <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_we       <= 1'b0;
            r_byte_end <= 1'b0;
            r_load     <= 1'b0;
            r_tx_valid <= 1'b0;
        end else begin
            r_we       <= 1'b0;
            r_byte_end <= 1'b0;
            r_load     <= 1'b0;
            if (r_csb_d) begin
                r_bit_cnt  <= '0;
                r_tx_sr    <= '0;
                r_rd       <= 1'b0;
                r_wr       <= 1'b0;
                r_tx_valid <= 1'b0;
            end else begin
                if (w_shift_en) begin
                    r_rx_sr   <= w_rx_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                end
                if (w_byte_done && r_state == ST_CMD) begin
                    r_rd <= w_rx_byte[6];
                    r_wr <= w_rx_byte[7];
                end
                if (w_byte_done && r_state == ST_ADDR) begin
                    r_addr <= ADDR_W'(w_rx_byte);
                    r_load <= r_rd;
                end
                if (w_shift_en && r_state == ST_DATA) begin
                    if (w_byte_done) begin
                        r_we       <= r_wr;
                        r_byte_end <= 1'b1;
                        if (r_wr) r_wdata <= w_rx_byte;
                    end else begin
                        r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                    end
                end
                // Increment one cycle after the strobe so the write sees the old address
                if (r_byte_end) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_load <= r_rd;
                end
                if (r_load) begin
                    r_tx_sr    <= reg_rdata;
                    r_tx_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        sdo_oe = 1'b0;
        sdo    = 1'b0;
        if (r_state == ST_DATA && r_rd && r_tx_valid && !r_csb_d) begin
            sdo_oe = 1'b1;
            sdo    = r_tx_sr[7];
        end
    end

    assign reg_addr  = r_addr;
    assign reg_we    = r_we;
    assign reg_wdata = r_wdata;
    assign busy      = ~r_csb_d;

endmodule

`default_nettype wire

// File: tb/tb_hkspi_responder.sv
// ============================================================================
// Module      : tb_hkspi_responder
// Description : Self-checking bench for hkspi_responder against a register
//               map model; honours HKSPI_RESP_NBYTE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hkspi_responder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sck   = 1'b0;
    logic       csb   = 1'b1;
    logic       sdi   = 1'b0;
    logic       sdo, sdo_oe, reg_we, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    logic [7:0] mem [256];
    logic [7:0] tx_buf [32];
    logic [7:0] rx_buf [32];
    logic [7:0] log_a [1024];
    logic [7:0] log_d [1024];
    int         we_cnt  = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;
    int         n_total = 0;
    logic       oe_all, oe_any, hdr_oe, data_oe_all, data_oe_any, busy_mid;

    assign reg_rdata = mem[reg_addr];

    always #12.5 clock = ~clock;

    hkspi_responder #(.ADDR_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .sck       (sck),
        .csb       (csb),
        .sdi       (sdi),
        .sdo       (sdo),
        .sdo_oe    (sdo_oe),
        .reg_addr  (reg_addr),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always @(posedge clock) begin
        if (reg_we) begin
            log_a[we_cnt % 1024] <= reg_addr;
            log_d[we_cnt % 1024] <= reg_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master samples sdo just before raising sck
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sdi = tx[i];
            #100;
            rx[i]  = sdo;
            oe_all = oe_all & sdo_oe;
            oe_any = oe_any | sdo_oe;
            sck = 1'b1;
            #100;
            sck = 1'b0;
        end
    endtask

    task automatic spi_txn(input logic [7:0] cmd, input logic [7:0] addr, input int n);
        logic [7:0] rx;
        csb = 1'b0;
        #200;
        oe_all = 1'b1; oe_any = 1'b0;
        spi_bits(cmd, 8, rx);
        busy_mid = busy;
        spi_bits(addr, 8, rx);
        hdr_oe = oe_any;
        oe_all = 1'b1; oe_any = 1'b0;
        for (int i = 0; i < n; i++) begin
            spi_bits(tx_buf[i], 8, rx);
            rx_buf[i] = rx;
        end
        data_oe_all = oe_all;
        data_oe_any = oe_any;
        #100 csb = 1'b1;
        #300;
    endtask

    // Compare logged strobes against a write stream of tx_buf from addr a
    task automatic chk_writes(input string tag, input int base, input logic [7:0] a, input int n);
        logic [7:0] ea;
        chk({tag, "_count"}, 32'(we_cnt - base), 32'(n));
        for (int i = 0; i < n && i < we_cnt - base; i++) begin
            ea = a + 8'(i);
            chk({tag, "_addr"}, 32'(log_a[(base + i) % 1024]), 32'(ea));
            chk({tag, "_data"}, 32'(log_d[(base + i) % 1024]), 32'(tx_buf[i]));
            mem[ea] = tx_buf[i];
        end
    endtask

    initial begin
        int         base, n;
        logic [7:0] a, cmd, rx, ea;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h00; mem[1] = 8'h04; mem[2] = 8'h56; mem[3] = 8'h11; mem[18] = 8'h04;
        for (int i = 0; i < 32; i++) tx_buf[i] = 8'h00;

        #100;
        chk("rst_sdo", 32'(sdo), 0);
        chk("rst_sdo_oe", 32'(sdo_oe), 0);
        chk("rst_reg_addr", 32'(reg_addr), 0);
        chk("rst_reg_we", 32'(reg_we), 0);
        chk("rst_reg_wdata", 32'(reg_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        #200;

        base = we_cnt; tx_buf[0] = 8'h01;
        spi_txn(8'h80, 8'h0B, 1);
        chk("wr1_busy", 32'(busy_mid), 1);
        chk_writes("wr1", base, 8'h0B, 1);
        chk("wr1_addr_inc", 32'(reg_addr), 32'h0C);

        base = we_cnt;
        spi_txn(8'h40, 8'h03, 1);
        chk("rd1_data", 32'(rx_buf[0]), 32'h11);
        chk("rd1_hdr_oe", 32'(hdr_oe), 0);
        chk("rd1_data_oe", 32'(data_oe_all), 1);
        chk("rd1_oe_after", 32'(sdo_oe), 0);
        chk("rd1_no_we", 32'(we_cnt - base), 0);

        base = we_cnt;
        spi_txn(8'h40, 8'h00, 19);
        for (int i = 0; i < 19; i++) chk("stream_rd", 32'(rx_buf[i]), 32'(mem[i]));
        chk("stream_rd_end_addr", 32'(reg_addr), 32'h13);
        chk("stream_rd_no_we", 32'(we_cnt - base), 0);

        base = we_cnt;
        tx_buf[0] = 8'($urandom); tx_buf[1] = 8'($urandom);
        spi_txn(8'h80, 8'hFF, 2);
        chk_writes("wrap", base, 8'hFF, 2);

        // Deselect after 5 bits of the data byte
        base = we_cnt;
        csb = 1'b0; #200;
        spi_bits(8'h80, 8, rx);
        spi_bits(8'($urandom), 8, rx);
        spi_bits(8'hA5, 5, rx);
        #100 csb = 1'b1; #300;
        chk("abort_no_we", 32'(we_cnt - base), 0);
        base = we_cnt; a = 8'($urandom); tx_buf[0] = 8'($urandom);
        spi_txn(8'h80, a, 1);
        chk_writes("post_abort", base, a, 1);

        for (int t = 0; t < 6; t++) begin
            case ($urandom_range(0, 2))
                0:       cmd = 8'h80;
                1:       cmd = 8'h40;
                default: cmd = 8'hC0;
            endcase
            a = 8'($urandom);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
            base = we_cnt;
            spi_txn(cmd, a, n);
            if (cmd[6]) begin
                for (int i = 0; i < n; i++) begin
                    ea = a + 8'(i);
                    chk("rnd_rd", 32'(rx_buf[i]), 32'(mem[ea]));
                end
            end
            chk("rnd_oe", 32'(data_oe_all), 32'(cmd[6]));
            chk_writes("rnd_wr", base, a, cmd[7] ? n : 0);
            chk("rnd_end_addr", 32'(reg_addr), 32'(8'(a + 8'(n))));
        end

        for (int t = 0; t < 3; t++) begin
            case (t)
                0:       cmd = 8'h00;
                1:       cmd = 8'h80 | 8'($urandom_range(1, 7));
                default: cmd = 8'h40 | 8'($urandom_range(1, 7));
            endcase
            base = we_cnt;
            spi_txn(cmd, 8'($urandom), 2);
            chk("bad_cmd_no_we", 32'(we_cnt - base), 0);
            chk("bad_cmd_no_oe", 32'(data_oe_any), 0);
        end

        base = we_cnt; a = 8'($urandom);
        for (int i = 0; i < 4; i++) tx_buf[i] = 8'($urandom);
        spi_txn(8'h90, a, 4);
`ifdef HKSPI_RESP_NBYTE_EN
        chk_writes("nbyte", base, a, 2);
`else
        chk_writes("nbyte", base, a, 0);
`endif

        base = we_cnt; tx_buf[0] = 8'hA5;
        spi_txn(8'h80, 8'h5A, 1);
        chk_writes("pre_rst", base, 8'h5A, 1);
        csb = 1'b0; #200;
        spi_bits(8'h40, 8, rx);
        spi_bits(8'h33, 3, rx);
        #50 reset = 1'b1;
        #1;
        chk("mid_rst_sdo", 32'(sdo), 0);
        chk("mid_rst_sdo_oe", 32'(sdo_oe), 0);
        chk("mid_rst_reg_addr", 32'(reg_addr), 0);
        chk("mid_rst_reg_we", 32'(reg_we), 0);
        chk("mid_rst_reg_wdata", 32'(reg_wdata), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        #99 reset = 1'b0;
        csb = 1'b1; #400;
        base = we_cnt; a = 8'($urandom); tx_buf[0] = 8'($urandom);
        spi_txn(8'h80, a, 1);
        chk_writes("post_rst", base, a, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
